aq_ifu_btb_ctrl: RTL
====================

# aq_ifu_btb_ctrl

Update/invalidate sequencer for the IFU branch target buffer entry array. It accepts branch-resolution update requests from the IFU and performs a tag lookup through the entries' write-access compare. It selects either the hitting entry or a replacement victim, then drives each entry's per-entry update, clear and clock-gate enables. It also executes whole-array invalidation on a cp0 request, and sits between the IFU branch-resolution path and the array of BTB entry instances.

## Interface
Parameters:
- ENTRY_NUM, 16, number of BTB entries; power of two, 2..64
- ADDR_WIDTH, 16, tag/target width

Ports:
- forever_cpuclk  in  1  clock
- cpurst_b  in  1  reset; asynchronous, active-low
- cp0_ifu_btb_en  in  1  BTB enable
- cp0_ifu_btb_inv  in  1  invalidate-all request (level-sampled)
- ifu_btb_upd_vld  in  1  update request valid
- ifu_btb_upd_rdy  out  1  update request ready
- ifu_btb_upd_del  in  1  request is a delete (clear the matching entry) rather than a write
- ifu_btb_upd_tag  in  ADDR_WIDTH  branch PC tag
- ifu_btb_upd_tgt  in  ADDR_WIDTH  branch target
- btb_entry_wr_hit  in  ENTRY_NUM  per-entry write-tag hit
- btb_entry_rd_hit  in  ENTRY_NUM  per-entry fetch-tag hit (replacement touch)
- btb_wr_acc_tag  out  ADDR_WIDTH  tag broadcast for write lookup
- btb_upd_tag / btb_upd_tgt  out  ADDR_WIDTH  write data broadcast to entries
- btb_entry_upd / btb_entry_updg  out  ENTRY_NUM  per-entry write enable / clock-gate enable
- btb_entry_clr / btb_entry_clrg  out  ENTRY_NUM  per-entry clear / clock-gate enable
- btb_ctrl_busy  out  1  state != IDLE

## Operation
- FSM states:
  - IDLE: accepts a request.
  - LOOKUP: latched tag on btb_wr_acc_tag; samples btb_entry_wr_hit.
  - WRITE: drives enables for the selected one-hot entry.
  - INV: btb_entry_clr/clrg all ones.
- Transitions:
  - IDLE, handshake with cp0_ifu_btb_en=1 -> LOOKUP.
  - LOOKUP -> WRITE.
  - WRITE -> IDLE.
  - Any state with cp0_ifu_btb_inv=1 at the clock edge -> INV; this has priority and drops any in-flight request.
  - INV -> INV while inv is held, else IDLE.
- ifu_btb_upd_rdy = (state==IDLE) && !cp0_ifu_btb_inv.
- With cp0_ifu_btb_en=0, a handshake is consumed and discarded and the FSM stays in IDLE.
- Handshake latches tag, tgt and del; latched values drive btb_wr_acc_tag/btb_upd_tag/btb_upd_tgt until the next handshake.
- Selection in LOOKUP, registered:
  - Any hit: lowest-index hitting entry.
  - No hit and write: victim.
  - No hit and delete: none (WRITE asserts nothing).
- WRITE, write request: upd=updg=sel.
- WRITE, delete request with hit: clr=clrg=sel.
- Replacement: on a write to a victim, the pointer advances. A hit write or a delete does not advance it. INV resets replacement state to 0.
- The 4 entry enable vectors are 0 in IDLE and LOOKUP.

## Timing
- Reset: state IDLE, all entry enables 0, btb_ctrl_busy 0, ifu_btb_upd_rdy 1 (when inv low), latched tag/tgt 0, replacement state 0.
- Handshake at edge N: LOOKUP in cycle N+1, WRITE in N+2, entry content updated at edge N+3, rdy again in cycle N+3. Sustained throughput is 1 request per 3 cycles.
- Invalidate sampled at edge N: all entries cleared at edge N+2 (INV in cycle N+1).
- Entry hit inputs are combinational from entry state; the request is sampled only in LOOKUP.
- Reset asserted mid-operation returns to IDLE immediately with no entry writes.

## Configuration
- AQ_IFU_BTB_PLRU_EN defined: tree pseudo-LRU with ENTRY_NUM-1 bits.
  - Touched by a WRITE to the selected entry.
  - Touched each cycle by the lowest-index btb_entry_rd_hit.
  - If both occur in the same cycle, only the write touch applies.
  - Victim = PLRU leaf.
- Undefined: log2(ENTRY_NUM)-bit round-robin pointer; btb_entry_rd_hit is ignored.

## Structure
- Shared package holds the FSM state encoding (IDLE=2'b00, LOOKUP=2'b01, WRITE=2'b10, INV=2'b11), the ADDR_WIDTH default and the ENTRY_NUM default.
- Sub-module aq_ifu_btb_victim holds the replacement state, with both macro variants behind one interface (touch valid/index, write-touch, clear, victim one-hot).
- The top level holds the FSM, request latches and enable decode.

## Test plan
- Reset, then write tag 0x1234 tgt 0x5678 with no hits: upd/updg = 16'h0001 in cycle N+2; next miss write selects 16'h0002.
- Write tag 0x1234 with btb_entry_wr_hit=16'h0020: upd=16'h0020; round-robin pointer unchanged.
- Delete with wr_hit=16'h0008: clr=clrg=16'h0008 in WRITE. Delete with no hit: all enables 0.
- cp0_ifu_btb_inv pulse during LOOKUP: next cycle clr/clrg=16'hFFFF, no upd asserted, pointer back to 0, rdy=1 two cycles later.
- cp0_ifu_btb_en=0 with vld=1: rdy=1, FSM stays IDLE, no entry enables asserted.
- With AQ_IFU_BTB_PLRU_EN defined: fill entries 0..15, then read-hit entry 0; the next miss write must not select entry 0.

Source files
------------

// File: rtl/aq_ifu_btb_ctrl_pkg.sv
// Shared definitions for the IFU BTB update/invalidate sequencer:
// FSM state encoding and default array geometry.
package aq_ifu_btb_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LOOKUP = 2'b01,
    WRITE  = 2'b10,
    INV    = 2'b11
  } btb_state_e;

  localparam int BTB_ENTRY_NUM_DEF  = 16;
  localparam int BTB_ADDR_WIDTH_DEF = 16;

endpackage

// File: rtl/aq_ifu_btb_victim.sv
// BTB replacement state. Round-robin pointer by default; tree pseudo-LRU
// when AQ_IFU_BTB_PLRU_EN is defined. Both variants share one interface.
module aq_ifu_btb_victim
  import aq_ifu_btb_ctrl_pkg::*;
#(
  parameter int ENTRY_NUM = BTB_ENTRY_NUM_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         touch_vld,
  input  logic                         touch_wr,
  input  logic                         touch_miss,
  input  logic [$clog2(ENTRY_NUM)-1:0] touch_idx,
  output logic [ENTRY_NUM-1:0]         victim_oh
);

  localparam int LW = $clog2(ENTRY_NUM);

`ifdef AQ_IFU_BTB_PLRU_EN
  // Each tree bit points toward the less recently used half (0 = left).
  logic [ENTRY_NUM-2:0] tree_q, tree_d;
  logic [LW:0]          node_t, node_v;
  logic [LW-1:0]        vic_idx;
  logic                 unused_plru;

  assign unused_plru = touch_wr ^ touch_miss;

  always_comb begin
    tree_d = tree_q;
    node_t = '0;
    if (clr) begin
      tree_d = '0;
    end else if (touch_vld) begin
      for (int l = 0; l < LW; l++) begin
        tree_d[node_t[LW-1:0]] = ~touch_idx[LW-1-l];
        node_t = (node_t << 1) + (LW+1)'(1) + (LW+1)'(touch_idx[LW-1-l]);
      end
    end
  end

  always_comb begin
    node_v = '0;
    for (int l = 0; l < LW; l++) begin
      node_v = (node_v << 1) + (LW+1)'(1) + (LW+1)'(tree_q[node_v[LW-1:0]]);
    end
    // Leaf n sits at heap node n+ENTRY_NUM-1, i.e. node+1 modulo ENTRY_NUM.
    vic_idx = node_v[LW-1:0] + LW'(1);
  end

  assign victim_oh = ENTRY_NUM'(1) << vic_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tree_q <= '0;
    else        tree_q <= tree_d;
  end
`else
  logic [LW-1:0] ptr_q, ptr_d;
  logic          unused_rr;

  assign unused_rr = ^touch_idx;

  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (touch_vld && touch_wr && touch_miss) begin
      ptr_d = ptr_q + LW'(1);
    end
  end

  assign victim_oh = ENTRY_NUM'(1) << ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`endif

endmodule

// File: rtl/aq_ifu_btb_ctrl.sv
// IFU BTB update/invalidate sequencer: IDLE->LOOKUP->WRITE per request, INV
// clears the whole array. Replacement policy selected by AQ_IFU_BTB_PLRU_EN.
module aq_ifu_btb_ctrl
  import aq_ifu_btb_ctrl_pkg::*;
#(
  parameter int ENTRY_NUM  = BTB_ENTRY_NUM_DEF,
  parameter int ADDR_WIDTH = BTB_ADDR_WIDTH_DEF
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  cp0_ifu_btb_en,
  input  logic                  cp0_ifu_btb_inv,
  input  logic                  ifu_btb_upd_vld,
  output logic                  ifu_btb_upd_rdy,
  input  logic                  ifu_btb_upd_del,
  input  logic [ADDR_WIDTH-1:0] ifu_btb_upd_tag,
  input  logic [ADDR_WIDTH-1:0] ifu_btb_upd_tgt,
  input  logic [ENTRY_NUM-1:0]  btb_entry_wr_hit,
  input  logic [ENTRY_NUM-1:0]  btb_entry_rd_hit,
  output logic [ADDR_WIDTH-1:0] btb_wr_acc_tag,
  output logic [ADDR_WIDTH-1:0] btb_upd_tag,
  output logic [ADDR_WIDTH-1:0] btb_upd_tgt,
  output logic [ENTRY_NUM-1:0]  btb_entry_upd,
  output logic [ENTRY_NUM-1:0]  btb_entry_updg,
  output logic [ENTRY_NUM-1:0]  btb_entry_clr,
  output logic [ENTRY_NUM-1:0]  btb_entry_clrg,
  output logic                  btb_ctrl_busy
);

  localparam int LW = $clog2(ENTRY_NUM);

  btb_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] tag_q, tag_d, tgt_q, tgt_d;
  logic                  del_q, del_d;
  logic [ENTRY_NUM-1:0]  sel_q, sel_d;
  logic [LW-1:0]         sel_idx_q, sel_idx_d;
  logic                  miss_q, miss_d;
  logic                  handshake, wr_touch, rd_touch;
  logic [ENTRY_NUM-1:0]  victim_oh;
  logic [LW-1:0]         wr_hit_idx, rd_hit_idx, vic_idx;

  assign ifu_btb_upd_rdy = (state_q == IDLE) && !cp0_ifu_btb_inv;
  assign handshake       = ifu_btb_upd_vld && ifu_btb_upd_rdy;
  assign btb_ctrl_busy   = (state_q != IDLE);
  assign btb_wr_acc_tag  = tag_q;
  assign btb_upd_tag     = tag_q;
  assign btb_upd_tgt     = tgt_q;

  // Descending scan leaves the lowest set index in each result.
  always_comb begin
    wr_hit_idx = '0;
    rd_hit_idx = '0;
    vic_idx    = '0;
    for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
      if (btb_entry_wr_hit[i]) wr_hit_idx = LW'(i);
      if (btb_entry_rd_hit[i]) rd_hit_idx = LW'(i);
      if (victim_oh[i])        vic_idx    = LW'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    tag_d     = tag_q;
    tgt_d     = tgt_q;
    del_d     = del_q;
    sel_d     = sel_q;
    sel_idx_d = sel_idx_q;
    miss_d    = miss_q;
    if (handshake) begin
      tag_d = ifu_btb_upd_tag;
      tgt_d = ifu_btb_upd_tgt;
      del_d = ifu_btb_upd_del;
    end
    case (state_q)
      IDLE: begin
        if (handshake && cp0_ifu_btb_en) state_d = LOOKUP;
      end
      LOOKUP: begin
        state_d = WRITE;
        if (|btb_entry_wr_hit) begin
          sel_d     = ENTRY_NUM'(1) << wr_hit_idx;
          sel_idx_d = wr_hit_idx;
          miss_d    = 1'b0;
        end else if (!del_q) begin
          sel_d     = victim_oh;
          sel_idx_d = vic_idx;
          miss_d    = 1'b1;
        end else begin
          sel_d     = '0;
          sel_idx_d = '0;
          miss_d    = 1'b0;
        end
      end
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (cp0_ifu_btb_inv) state_d = INV;
  end

  always_comb begin
    btb_entry_upd  = '0;
    btb_entry_updg = '0;
    btb_entry_clr  = '0;
    btb_entry_clrg = '0;
    if (state_q == WRITE) begin
      if (!del_q) begin
        btb_entry_upd  = sel_q;
        btb_entry_updg = sel_q;
      end else begin
        btb_entry_clr  = sel_q;
        btb_entry_clrg = sel_q;
      end
    end else if (state_q == INV) begin
      btb_entry_clr  = '1;
      btb_entry_clrg = '1;
    end
  end

  // A write touch wins over a same-cycle read-hit touch.
  assign wr_touch = (state_q == WRITE) && !del_q;
  assign rd_touch = |btb_entry_rd_hit;

  aq_ifu_btb_victim #(.ENTRY_NUM(ENTRY_NUM)) u_victim (
    .clk        (forever_cpuclk),
    .rst_n      (cpurst_b),
    .clr        (state_q == INV),
    .touch_vld  (wr_touch || rd_touch),
    .touch_wr   (wr_touch),
    .touch_miss (miss_q),
    .touch_idx  (wr_touch ? sel_idx_q : rd_hit_idx),
    .victim_oh  (victim_oh)
  );

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q   <= IDLE;
      tag_q     <= '0;
      tgt_q     <= '0;
      del_q     <= 1'b0;
      sel_q     <= '0;
      sel_idx_q <= '0;
      miss_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tag_q     <= tag_d;
      tgt_q     <= tgt_d;
      del_q     <= del_d;
      sel_q     <= sel_d;
      sel_idx_q <= sel_idx_d;
      miss_q    <= miss_d;
    end
  end

endmodule
